// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, decoder and Moore control FSM for a
// simple 16-bit datapath. The IR is captured only while idle. The FSM then
// sequences the instruction through operand fetch, execute and write-back.
// All control outputs are registered. The output word for the state being
// entered is computed from the next state and registered together with the
// state, so the outputs always match the current state.
module cpu_controller #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [IW-1:0] in,
  output logic          w,
  output logic          halted,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic [3:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_EXEC      = 3'd5,
    S_WRITE_REG = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  // Instruction classes produced by the decoder
  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_MOVI = 3'd1;
  localparam logic [2:0] C_MOVR = 3'd2;
  localparam logic [2:0] C_ALU  = 3'd3;
  localparam logic [2:0] C_HALT = 3'd4;

  typedef struct packed {
    logic       w;
    logic       halted;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  state_t          state_r;
  state_t          state_nx_s;
  ctrl_t           ctrl_r;
  ctrl_t           ctrl_nx_s;
  logic [IW-1:0]   ir_r;

  // Classify an instruction word; unrecognised encodings fall through to NOP
  function automatic logic [2:0] decode_class(input logic [IW-1:0] ir);
    logic [2:0] cls;
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) begin
      cls = C_MOVI;
    end else if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) begin
      cls = C_MOVR;
    end else if (ir[15:13] == 3'b101) begin
      cls = C_ALU;
    end else if (ir[15:13] == 3'b111 && ir[12:11] == 2'b00) begin
      cls = C_HALT;
    end else begin
      cls = C_NOP;
    end
    return cls;
  endfunction

  // Moore output word for a given state; unlisted outputs are 0, vsel selects C
  function automatic ctrl_t ctrl_for(input state_t st, input logic [IW-1:0] ir);
    ctrl_t c;
    c      = '0;
    c.vsel = 4'b0001;
    case (st)
      S_WAIT: begin
        c.w = 1'b1;
      end
      S_DECODE: begin
        c.w = 1'b0;
      end
      S_WRITE_IMM: begin
        c.readnum  = ir[10:8];
        c.writenum = ir[10:8];
        c.vsel     = 4'b0100;
        c.write    = 1'b1;
      end
      S_GET_A: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = ir[4:3];
        c.bsel  = 1'b0;
        if (ir[15:13] == 3'b110) begin
          // MOV reg: pass the shifted B through the adder with A forced to zero
          c.asel  = 1'b1;
          c.aluop = 2'b00;
          c.loadc = 1'b1;
        end else if (ir[12:11] == 2'b01) begin
          // CMP only updates status, never C
          c.aluop = 2'b01;
          c.loads = 1'b1;
        end else begin
          c.aluop = ir[12:11];
          c.loadc = 1'b1;
        end
      end
      S_WRITE_REG: begin
        c.writenum = ir[7:5];
        c.write    = 1'b1;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c.w = 1'b1;
      end
    endcase
    return c;
  endfunction

  // Immediates are combinational views of the IR
  assign sximm8 = {{(IW-8){ir_r[7]}}, ir_r[7:0]};
  assign sximm5 = {{(IW-5){ir_r[4]}}, ir_r[4:0]};

  // Capture the instruction only while idle; loads in any other state are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_r <= {IW{1'b0}};
    end else if (load && state_r == S_WAIT) begin
      ir_r <= in;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Next-state logic of the control sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_WAIT: begin
        if (s) begin
          state_nx_s = S_DECODE;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_DECODE: begin
        case (decode_class(ir_r))
          C_MOVI:  state_nx_s = S_WRITE_IMM;
          C_MOVR:  state_nx_s = S_GET_B;
          C_ALU:   state_nx_s = S_GET_A;
          C_HALT:  state_nx_s = S_HALT;
          default: state_nx_s = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_nx_s = S_WAIT;
      S_GET_A:     state_nx_s = S_GET_B;
      S_GET_B:     state_nx_s = S_EXEC;
      S_EXEC: begin
        if (ir_r[15:13] == 3'b101 && ir_r[12:11] == 2'b01) begin
          state_nx_s = S_WAIT;
        end else begin
          state_nx_s = S_WRITE_REG;
        end
      end
      S_WRITE_REG: state_nx_s = S_WAIT;
      S_HALT:      state_nx_s = S_HALT;
      default:     state_nx_s = S_WAIT;
    endcase
  end

  // Output word for the state about to be entered
  always_comb begin
    ctrl_nx_s = ctrl_for(state_nx_s, ir_r);
  end

  // State and control outputs advance together; reset aborts to idle at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_WAIT;
      ctrl_r  <= ctrl_for(S_WAIT, {IW{1'b0}});
    end else begin
      state_r <= state_nx_s;
      ctrl_r  <= ctrl_nx_s;
    end
  end

  assign w        = ctrl_r.w;
  assign halted   = ctrl_r.halted;
  assign readnum  = ctrl_r.readnum;
  assign writenum = ctrl_r.writenum;
  assign write    = ctrl_r.write;
  assign vsel     = ctrl_r.vsel;
  assign loada    = ctrl_r.loada;
  assign loadb    = ctrl_r.loadb;
  assign loadc    = ctrl_r.loadc;
  assign loads    = ctrl_r.loads;
  assign asel     = ctrl_r.asel;
  assign bsel     = ctrl_r.bsel;
  assign shift    = ctrl_r.shift;
  assign ALUop    = ctrl_r.aluop;

endmodule
